// File: rtl/div_pkg.sv
// Shared definitions for the shift-and-subtract divider.
//   state_t    : controller states (IDLE, CALC, DONE)
//   DEF_WIDTH  : default operand/result width
package div_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One iteration of binary long division (purely combinational).
// Ports:
//   rem_in   [WIDTH:0]   partial remainder before this step
//   dvd_msb              dividend bit shifted into the remainder
//   divisor  [WIDTH-1:0] divisor
//   rem_out  [WIDTH:0]   partial remainder after this step
//   qbit                 quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             qbit
);

    // The remainder stays below the divisor between steps, so the top bit of
    // t is zero in practice; it is kept so the compare is exact for any input.
    logic [WIDTH+1:0] t;

    always_comb begin
        t       = {rem_in, dvd_msb};
        qbit    = (t >= {2'b00, divisor});
        rem_out = qbit ? (t[WIDTH:0] - {1'b0, divisor}) : t[WIDTH:0];
    end

endmodule

// File: rtl/shift_subtract_divider.sv
// Sequential unsigned divider: one quotient bit per clock, start/done handshake.
// Optional feature macro: DIV_BY_ZERO_EN (adds div_zero port and a fast
// path that skips the iterations when the divisor is zero).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request, sampled only while idle
//   dividend, divisor     operands, sampled with start
//   busy                  high whenever not idle
//   done                  one-cycle pulse when quotient/remainder are valid
//   quotient, remainder   registered results, held until next done
//   div_zero              (DIV_BY_ZERO_EN only) last result had a zero divisor
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, one quotient bit per cycle
// DONE  | results valid, done asserted for this cycle
module shift_subtract_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
`ifdef DIV_BY_ZERO_EN
    output logic             div_zero,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   rem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_nxt;
    logic             qbit;
    logic             last_step;
    logic             zero_div;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_msb (dvd_q[WIDTH-1]),
        .divisor (divisor_q),
        .rem_out (rem_nxt),
        .qbit    (qbit)
    );

    assign last_step = (cnt_q == CW'(1));

`ifdef DIV_BY_ZERO_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_div ? DONE : CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_BY_ZERO_EN
            div_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_q     <= dividend;
                        divisor_q <= divisor;
                        rem_q     <= '0;
                        cnt_q     <= CW'(WIDTH);
`ifdef DIV_BY_ZERO_EN
                        // Fast path: same values the full iteration would give.
                        if (zero_div) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
                    dvd_q <= {dvd_q[WIDTH-2:0], qbit};
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_step) begin
                        quotient  <= {dvd_q[WIDTH-2:0], qbit};
                        remainder <= rem_nxt[WIDTH-1:0];
`ifdef DIV_BY_ZERO_EN
                        div_zero  <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
